// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//
// Purpose:
//   This is a two-stage pipelined execute slot wrapped around an external
//   16-bit combinational shifter.
//   - Stage A latches a decoded shift operation from register-read. It drives
//     the shifter inputs straight from its own registers.
//   - Stage B captures the shifter result together with the carry and
//     illegal-op flags. It presents them to writeback over a valid/ready
//     handshake.
//   The stage adds three things the bare shifter does not have: backpressure,
//   a carry-out flag, and illegal-op detection.
//
// Configuration macro:
//   SHIFT_ISSUE_SAT_AMT_EN
//     - Defined: any nonzero bit in in_b[15:5] saturates the shift amount
//       to 16.
//     - Undefined: only in_b[4:0] is used and the upper bits are ignored.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   upstream presents an operation
//   in_ready   stage A can accept an operation this cycle
//   in_op      operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal
//   in_a       value to shift
//   in_b       shift amount source
//   in_tag     destination register tag
//   sh_in      shifter data input (stage A operand)
//   sh_amt     shifter amount
//   sh_mode    shifter mode (1 = arithmetic)
//   sh_dir     shifter direction (1 = right)
//   sh_out     shifter result; combinational from sh_*
//   out_valid  stage B holds a result
//   out_ready  downstream accepts the result
//   out_data   result value
//   out_tag    tag of the result
//   out_zero   out_data == 0
//   out_neg    out_data[15]
//   out_carry  last bit shifted out
//   out_err    the operation was illegal
// -----------------------------------------------------------------------------
module shift_issue_stage #(
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,

    output logic [15:0]      sh_in,
    output logic [4:0]       sh_amt,
    output logic             sh_mode,
    output logic             sh_dir,
    input  logic [15:0]      sh_out,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_err
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // ------------------------------------------------------------------
    // Stage A state
    // ------------------------------------------------------------------
    logic             valid_a_q, valid_a_d;
    logic [15:0]      a_q, a_d;
    logic [4:0]       amt_q, amt_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             err_a_q, err_a_d;
    logic [TAG_W-1:0] tag_a_q, tag_a_d;

    // ------------------------------------------------------------------
    // Stage B state
    // ------------------------------------------------------------------
    logic             valid_b_q, valid_b_d;
    logic [15:0]      data_q, data_d;
    logic [TAG_W-1:0] tag_b_q, tag_b_d;
    logic             carry_b_q, carry_b_d;
    logic             err_b_q, err_b_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic adv_b;
    logic load_a;

    // Stage A moves into B when B is empty or B is draining this cycle.
    assign adv_b    = valid_a_q && (!valid_b_q || out_ready);
    // Stage A can take a new op when it is empty or it is draining into B.
    assign in_ready = !valid_a_q || adv_b;
    assign load_a   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Decode of the incoming operation
    // ------------------------------------------------------------------
    logic [4:0] dec_amt_raw;
    logic [4:0] dec_amt;
    logic       dec_mode;
    logic       dec_dir;
    logic       dec_err;

`ifdef SHIFT_ISSUE_SAT_AMT_EN
    // Any amount of 32 or more saturates to 16. That gives a full clear for
    // logical shifts and a full sign fill for SRA.
    always_comb begin
        dec_amt_raw = in_b[4:0];
        if (in_b[15:5] != 11'd0) begin
            dec_amt_raw = 5'd16;
        end
    end
`else
    // Upper amount bits are deliberately ignored in this build.
    logic unused_in_b_hi;
    assign unused_in_b_hi = ^in_b[15:5];
    assign dec_amt_raw    = in_b[4:0];
`endif

    always_comb begin
        dec_amt  = dec_amt_raw;
        dec_mode = 1'b0;
        dec_dir  = 1'b0;
        dec_err  = 1'b0;
        unique case (in_op)
            OP_SLL: begin
                dec_dir  = 1'b0;
                dec_mode = 1'b0;
            end
            OP_SRL: begin
                dec_dir  = 1'b1;
                dec_mode = 1'b0;
            end
            OP_SRA: begin
                dec_dir  = 1'b1;
                dec_mode = 1'b1;
            end
            OP_ILL: begin
                // A left shift by zero passes the operand through the shifter.
                dec_amt = 5'd0;
                dec_err = 1'b1;
            end
            default: begin
                dec_amt = 5'd0;
                dec_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shifter drive: taken straight from the stage A registers
    // ------------------------------------------------------------------
    assign sh_in   = a_q;
    assign sh_amt  = amt_q;
    assign sh_mode = mode_q;
    assign sh_dir  = dir_q;

    // ------------------------------------------------------------------
    // Carry: the last bit shifted out, taken from the stage A operand
    // ------------------------------------------------------------------
    logic       carry_a;
    logic [3:0] idx_left;
    logic [3:0] idx_right;

    // Only used when 1 <= amt <= 16, so the 4-bit truncation is exact.
    assign idx_left  = 4'(5'd16 - amt_q);
    assign idx_right = 4'(amt_q - 5'd1);

    always_comb begin
        carry_a = 1'b0;
        if (amt_q != 5'd0) begin
            if (!dir_q) begin
                if (amt_q <= 5'd16) begin
                    carry_a = a_q[idx_left];
                end
            end else begin
                if (amt_q <= 5'd16) begin
                    carry_a = a_q[idx_right];
                end else begin
                    // Past the operand width, SRA keeps shifting out copies
                    // of the sign bit.
                    carry_a = mode_q & a_q[15];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        valid_a_d = valid_a_q;
        a_d       = a_q;
        amt_d     = amt_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        err_a_d   = err_a_q;
        tag_a_d   = tag_a_q;

        if (load_a) begin
            valid_a_d = 1'b1;
            a_d       = in_a;
            amt_d     = dec_amt;
            mode_d    = dec_mode;
            dir_d     = dec_dir;
            err_a_d   = dec_err;
            tag_a_d   = in_tag;
        end else if (adv_b) begin
            valid_a_d = 1'b0;
        end
    end

    always_comb begin
        valid_b_d = valid_b_q;
        data_d    = data_q;
        tag_b_d   = tag_b_q;
        carry_b_d = carry_b_q;
        err_b_d   = err_b_q;

        if (adv_b) begin
            valid_b_d = 1'b1;
            data_d    = sh_out;
            tag_b_d   = tag_a_q;
            carry_b_d = carry_a;
            err_b_d   = err_a_q;
        end else if (out_ready) begin
            valid_b_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_a_q <= 1'b0;
            a_q       <= '0;
            amt_q     <= '0;
            mode_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_a_q   <= 1'b0;
            tag_a_q   <= '0;
            valid_b_q <= 1'b0;
            data_q    <= '0;
            tag_b_q   <= '0;
            carry_b_q <= 1'b0;
            err_b_q   <= 1'b0;
        end else begin
            valid_a_q <= valid_a_d;
            a_q       <= a_d;
            amt_q     <= amt_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            err_a_q   <= err_a_d;
            tag_a_q   <= tag_a_d;
            valid_b_q <= valid_b_d;
            data_q    <= data_d;
            tag_b_q   <= tag_b_d;
            carry_b_q <= carry_b_d;
            err_b_q   <= err_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = valid_b_q;
    assign out_data  = data_q;
    assign out_tag   = tag_b_q;
    assign out_carry = carry_b_q;
    assign out_err   = err_b_q;
    assign out_neg   = data_q[15];
    // Gated by valid so the cleared data register does not flag zero out
    // of reset.
    assign out_zero  = valid_b_q && (data_q == 16'd0);

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Table-driven bench for shift_issue_stage.
// - The external shifter is modelled behaviourally.
// - Expected results are pushed to a scoreboard queue on each accept.
// - Each result is popped and compared when it transfers out.
// - All time advances through tick(), so one process owns every counter.
// -----------------------------------------------------------------------------
module tb_shift_issue_stage;

    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [15:0]      sh_in;
    logic [4:0]       sh_amt;
    logic             sh_mode;
    logic             sh_dir;
    logic [15:0]      sh_out;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_err;

    shift_issue_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .sh_in     (sh_in),
        .sh_amt    (sh_amt),
        .sh_mode   (sh_mode),
        .sh_dir    (sh_dir),
        .sh_out    (sh_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_carry (out_carry),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Behavioural external shifter.
    always_comb begin
        if (!sh_dir)      sh_out = sh_in << sh_amt;
        else if (!sh_mode) sh_out = sh_in >> sh_amt;
        else              sh_out = $signed(sh_in) >>> sh_amt;
    end

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             err;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    exp_t sb[$];
    int   pop_cyc[$];
    exp_t pend_exp;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_pops = 0;
    int   rdy_release = 0;
    bit   rand_rdy = 1'b0;

    // Reference model. The carry is read from a widened shift result.
    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [TAG_W-1:0] tag);
        exp_t        e;
        int          amt;
        logic [31:0] t;
        amt = int'(b[4:0]);
`ifdef SHIFT_ISSUE_SAT_AMT_EN
        if (b[15:5] != 11'd0) amt = 16;
`endif
        e.tag = tag;
        e.err = 1'b0;
        case (op)
            2'b00: begin
                t = {16'd0, a} << amt;
                e.data = t[15:0];
                e.carry = t[16];
            end
            2'b01: begin
                t = {a, 16'd0} >> amt;
                e.data = t[31:16];
                e.carry = t[15];
            end
            2'b10: begin
                t = $signed({a, 16'd0}) >>> amt;
                e.data = t[31:16];
                e.carry = t[15];
            end
            default: begin
                e.data = a;
                e.carry = 1'b0;
                e.err = 1'b1;
            end
        endcase
        e.zero = (e.data == 16'd0);
        e.neg = e.data[15];
        return e;
    endfunction

    function automatic exp_t vec_exp(input int i);
        exp_t e;
        e.data  = vecs[i].data;
        e.tag   = TAG_W'(i);
        e.zero  = vecs[i].zero;
        e.neg   = vecs[i].neg;
        e.carry = vecs[i].carry;
        e.err   = vecs[i].err;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // One clock.
    // - Negedge: sample the handshakes; push on accept, pop and compare on
    //   a result transfer.
    // - Posedge + 1: update the ready pattern.
    task automatic tick(output bit acc, output bit ov);
        exp_t got;
        exp_t e;
        @(negedge clk);
        acc = !reset && in_valid && in_ready;
        ov  = out_valid;
        if (acc) sb.push_back(pend_exp);
        if (!reset && out_valid && out_ready) begin
            got = {out_data, out_tag, out_zero, out_neg, out_carry, out_err};
            pop_cyc.push_back(cyc);
            n_pops++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got result %h with nothing outstanding, required none",
                         got);
            end else begin
                e = sb.pop_front();
                chk("sb_result", 64'(got), 64'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rdy_release > 0) begin
            rdy_release--;
            if (rdy_release == 0) out_ready = 1'b1;
        end
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [TAG_W-1:0] tag, input exp_t e, output int waited);
        bit acc;
        bit ov;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        pend_exp = e;
        waited   = 0;
        acc      = 1'b0;
        while (!acc) begin
            tick(acc, ov);
            if (!acc) begin
                waited++;
                if (waited > 100) begin
                    chk("send_timeout", 64'(waited), 64'd0);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int i, output int waited);
        send(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i), vec_exp(i), waited);
    endtask

    task automatic drain(input string name);
        bit acc;
        bit ov;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick(acc, ov);
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        bit acc;
        bit ov;
        int w;
        int pops0;
        exp_t e;
        logic [1:0] rop;
        logic [15:0] ra;
        logic [15:0] rb;

        //            op     a         b         data      z     n     c     e
        vecs[0]  = '{2'b00, 16'h8001, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 16'h8004, 16'h0003, 16'hF000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 16'h8004, 16'h0003, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{2'b11, 16'h1234, 16'h00FF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{2'b01, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 16'h0001, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b10, 16'h8000, 16'h0010, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{2'b01, 16'h8000, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 16'h8000, 16'h0014, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 16'hFFFF, 16'h0014, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'b00, 16'hFFFF, 16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SHIFT_ISSUE_SAT_AMT_EN
        vecs[13] = '{2'b00, 16'h0003, 16'h0021, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{2'b10, 16'h8000, 16'h0100, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        vecs[13] = '{2'b00, 16'h0003, 16'h0021, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{2'b10, 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 16'd0;
        in_b      = 16'd0;
        in_tag    = '0;
        out_ready = 1'b0;
        pend_exp  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("reset_state",
            64'({out_valid, in_ready, sh_in, sh_amt, sh_mode, sh_dir,
                 out_data, out_tag, out_zero, out_neg, out_carry, out_err}),
            64'({1'b0, 1'b1, 46'd0}));
        @(posedge clk);
        #1;

        // Latency: out_valid appears on the second edge after the accept.
        out_ready = 1'b1;
        send_vec(0, w);
        tick(acc, ov);
        chk("latency_a_only", 64'(ov), 64'd0);
        tick(acc, ov);
        chk("latency_b_valid", 64'(ov), 64'd1);
        drain("latency_drain");

        // Back-to-back: in_ready stays high and results come out on
        // consecutive cycles.
        pop_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            send_vec(i, w);
            chk("b2b_in_ready", 64'(w), 64'd0);
        end
        drain("b2b_drain");
        chk("b2b_count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4)
            chk("b2b_consecutive", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        // Rest of the table, streamed.
        for (int i = 5; i < NV; i++) send_vec(i, w);
        drain("table_drain");

        // Stall: B holds its result, A fills, and in_ready drops.
        out_ready = 1'b0;
        send_vec(0, w);
        send_vec(1, w);
        chk("stall_second_accept", 64'(w), 64'd0);
        e = vec_exp(0);
        for (int k = 0; k < 3; k++) begin
            tick(acc, ov);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_hold",
                64'({out_valid, out_data, out_tag, out_zero, out_neg, out_carry, out_err}),
                64'({1'b1, e}));
        end
        rdy_release = 2;
        send_vec(2, w);
        chk("stall_backpressure", 64'(w != 0), 64'd1);
        drain("stall_drain");

        // Reset with both stages full: everything in flight is discarded.
        out_ready = 1'b0;
        send_vec(3, w);
        send_vec(4, w);
        reset = 1'b1;
        tick(acc, ov);
        chk("reset_flush", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        sb.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        pops0 = n_pops;
        repeat (5) tick(acc, ov);
        chk("reset_no_pulse", 64'(n_pops - pops0), 64'd0);

        // Random operations under random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
            send(rop, ra, rb, TAG_W'(i), model(rop, ra, rb, TAG_W'(i)), w);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Two-stage pipelined execute slot that sits around the 16-bit combinational shifter.
- Stage A latches a decoded shift operation from the register-read stage and drives the shifter's in/amt/mode/dir inputs.
- Stage B captures the shifter result plus flags and hands it to writeback over a valid/ready handshake.
- Provides backpressure, a carry-out flag and illegal-op detection that the shifter itself lacks.

Parameters:
- TAG_W, 3: width of the destination-register tag carried alongside each operation.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage A can accept this cycle
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 illegal
- in_a  input  16  value to shift
- in_b  input  16  shift amount source
- in_tag  input  TAG_W  destination tag
- sh_in  output  16  to shifter data input (stage A operand)
- sh_amt  output  5  to shifter amount
- sh_mode  output  1  to shifter mode (1 = arithmetic)
- sh_dir  output  1  to shifter dir (1 = right)
- sh_out  input  16  from shifter result (combinational from sh_*)
- out_valid  output  1  stage B holds a result
- out_ready  input  1  downstream accepts
- out_data  output  16  result
- out_tag  output  TAG_W  tag of result
- out_zero  output  1  out_data == 0
- out_neg  output  1  out_data[15]
- out_carry  output  1  last bit shifted out
- out_err  output  1  op was illegal

Behaviour:
- Reset (synchronous, active-high, clk rising edge) clears valid_a and valid_b, all stage registers, all out_* and sh_* to 0. in_ready reads 1 the cycle after reset deasserts.
- Decode (stage A load):
  - SLL: dir=0, mode=0.
  - SRL: dir=1, mode=0.
  - SRA: dir=1, mode=1.
  - 11: dir=0, mode=0, amt forced to 0 (passthrough); err bit set.
- Amount: amt_a = in_b[4:0] (see Optional Feature).
- sh_in/sh_amt/sh_mode/sh_dir are driven directly from stage A registers.
- Carry, computed in stage A from a_reg and amt_a, registered into B:
  - amt 0: carry 0.
  - SLL with amt 1..16: a[16-amt]; amt > 16: 0.
  - SRL/SRA with amt 1..16: a[amt-1].
  - SRL with amt > 16: 0. SRA with amt > 16: a[15].
- Handshake:
  - adv_b = valid_a && (!valid_b || out_ready).
  - in_ready = !valid_a || adv_b.
  - A loads when in_valid && in_ready.
  - B loads sh_out, flags, tag and err when adv_b; otherwise B holds.
  - valid_b clears when out_ready && !adv_b.
- Latency: 2 cycles from in accept to out_valid; full throughput of 1 op/cycle when out_ready is held high.
- Stall: out_valid=1, out_ready=0 → B holds all outputs stable. A holds its operation. in_ready=0 once A is also full.
- Simultaneous: A drains into B and a new op loads A in the same cycle with no bubble.
- out_zero and out_neg derive from the registered result, never from sh_out.
- Illegal op: out_data=in_a, carry 0, out_err=1; it flows through the pipeline normally.
- Reset mid-operation: in-flight ops are discarded with no output pulse.

Optional Feature:
- Macro: SHIFT_ISSUE_SAT_AMT_EN.
- Defined: if in_b[15:5] != 0, amt_a is forced to 16. This gives SLL/SRL result 0 and SRA result sign-fill. Carry follows the amt=16 rule: SLL a[0], SRL/SRA a[15].
- Undefined: amt_a = in_b[4:0]; upper bits of in_b are ignored (in_b=0x0021 shifts by 1).

Test Plan:
- SLL a=0x8001, b=3, out_ready=1 → 2 cycles later out_data=0x0008, carry=0, zero=0, neg=0.
- SRA a=0x8004, b=3 → 0xF000, carry=1, neg=1. SRL same operands → 0x1000, carry=1.
- Back-to-back 4 ops with out_ready=1 → 4 consecutive out_valid cycles, tags in order, in_ready never drops.
- out_ready=0 for 3 cycles after first result, 3 ops offered → in_ready drops after the second accept, outputs stable. Release → results drain in order with no loss or duplication.
- op=11, a=0x1234 → out_data=0x1234, out_err=1. SRL a=0x0001, b=1 → 0x0000, zero=1, carry=1.
- Reset asserted with both stages full → next cycle out_valid=0, in_ready=1. With SHIFT_ISSUE_SAT_AMT_EN, SRA a=0x8000, b=0x0100 → 0xFFFF, carry=1.
